cordic_cos_sin: RTL and testbench

- Iterative CORDIC rotation engine directly downstream of the float-to-fixed converter.
- Consumes the converter's sign / 1-bit integer / 19-bit fraction angle in radians and produces cos and sin in signed fixed point.
- One micro-rotation per clock, with a start/done handshake compatible with a multi-cycle custom-instruction slot.
- Feeds the fixed-to-float stage.

---
 rtl/cordic_cos_sin.sv | 81 ++++++++
 tb/tb_cordic_cos_sin.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cordic_cos_sin.sv
// cordic_cos_sin: iterative CORDIC rotation producing cos/sin (Q2.20) from a sign/int/frac angle.
// One micro-rotation per clock with a start/done handshake.
module cordic_cos_sin #(
  parameter int ITER = 16,
  parameter int W = 22
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                sign_i,
  input  logic                integer_i,
  input  logic [18:0]         fractional_i,
  output logic                busy_o,
  output logic                done_o,
  output logic signed [W-1:0] cos_o,
  output logic signed [W-1:0] sin_o,
  output logic                range_err_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [19:0] ATAN [20] = '{
    20'd823550, 20'd486170, 20'd256879, 20'd130396, 20'd65451,
    20'd32757,  20'd16383,  20'd8192,   20'd4096,   20'd2048,
    20'd1024,   20'd512,    20'd256,    20'd128,    20'd64,
    20'd32,     20'd16,     20'd8,      20'd4,      20'd2
  };
  state_t              r_state;
  logic signed [W-1:0] r_x, r_y, r_z;
  logic [4:0]          r_i;
  logic                r_rerr;
  logic [W-1:0]        w_mag;
  logic signed [W-1:0] w_atan, w_dx, w_dy;
  logic                w_neg;
  assign w_mag  = {{(W-21){1'b0}}, integer_i, fractional_i, 1'b0};
  assign w_atan = {{(W-20){1'b0}}, ATAN[r_i]};
  assign w_dx   = r_y >>> r_i;
  assign w_dy   = r_x >>> r_i;
  assign w_neg  = r_z[W-1];
  assign busy_o = (r_state != IDLE);
  // range flag is captured on accept but published with the results so outputs stay stable mid-run
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_i         <= '0;
      r_rerr      <= 1'b0;
      done_o      <= 1'b0;
      cos_o       <= '0;
      sin_o       <= '0;
      range_err_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_x     <= W'(636751);
          r_y     <= '0;
          r_z     <= sign_i ? -$signed(w_mag) : $signed(w_mag);
          r_i     <= '0;
          r_rerr  <= (w_mag > W'(1827976));
          r_state <= RUN;
        end
        RUN: begin
          r_x     <= w_neg ? r_x + w_dx : r_x - w_dx;
          r_y     <= w_neg ? r_y - w_dy : r_y + w_dy;
          r_z     <= w_neg ? r_z + w_atan : r_z - w_atan;
          r_i     <= r_i + 5'd1;
          r_state <= (r_i == 5'(ITER-1)) ? DONE : RUN;
        end
        DONE: begin
          cos_o       <= r_x;
          sin_o       <= r_y;
          range_err_o <= r_rerr;
          done_o      <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_cos_sin.sv
// tb_cordic_cos_sin: directed self-checking bench for cordic_cos_sin.
module tb_cordic_cos_sin;
  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               sign_i = 1'b0;
  logic               integer_i = 1'b0;
  logic [18:0]        fractional_i = '0;
  logic               busy_o, done_o, range_err_o;
  logic signed [21:0] cos_o, sin_o;
  int checks = 0;
  int failures = 0;
  int lat, nd, d0, d1, n;

  cordic_cos_sin dut (
    .clk(clk), .reset(reset), .start(start), .sign_i(sign_i), .integer_i(integer_i),
    .fractional_i(fractional_i), .busy_o(busy_o), .done_o(done_o), .cos_o(cos_o),
    .sin_o(sin_o), .range_err_o(range_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint act, input longint exp, input longint tol);
    checks++;
    assert ((act - exp) <= tol && (exp - act) <= tol) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d tol=%0d", tag, act, exp, tol);
    end
  endtask

  task automatic op(input logic s, input logic in, input logic [18:0] fr, output int l);
    @(negedge clk);
    sign_i = s; integer_i = in; fractional_i = fr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    l = 0;
    while (!done_o && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_cos", cos_o, 0, 0);
    chk("rst_sin", sin_o, 0, 0);
    chk("rst_busy", busy_o, 0, 0);
    chk("rst_done", done_o, 0, 0);
    chk("rst_rerr", range_err_o, 0, 0);
    nd = 0;
    repeat (5) begin @(posedge clk); #1; if (done_o) nd++; end
    chk("idle_no_done", nd, 0, 0);

    op(1'b0, 1'b0, 19'd0, lat);
    chk("zero_lat", lat, 17, 0);
    chk("zero_cos", cos_o, 1048576, 32);
    chk("zero_sin", sin_o, 0, 32);
    chk("zero_rerr", range_err_o, 0, 0);
    @(posedge clk); #1;
    chk("done_pulse", done_o, 0, 0);
    chk("hold_cos", cos_o, 1048576, 32);

    op(1'b1, 1'b0, 19'd0, lat);
    chk("nzero_cos", cos_o, 1048576, 32);
    chk("nzero_sin", sin_o, 0, 32);

    op(1'b0, 1'b1, 19'd24745, lat);
    chk("pi3_lat", lat, 17, 0);
    chk("pi3_cos", cos_o, 524288, 32);
    chk("pi3_sin", sin_o, 908093, 32);

    // accept 0.5 rad, then hold start high with different inputs while running
    @(negedge clk);
    sign_i = 1'b0; integer_i = 1'b0; fractional_i = 19'd262144; start = 1'b1;
    @(posedge clk); #1;
    chk("run_busy", busy_o, 1, 0);
    sign_i = 1'b1; integer_i = 1'b1; fractional_i = 19'd0;
    n = 0;
    while (!done_o && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 8) chk("midrun_hold_cos", cos_o, 524288, 32);
    end
    start = 1'b0;
    chk("mid_lat", n, 17, 0);
    chk("mid_cos", cos_o, 920192, 32);
    chk("mid_sin", sin_o, 502704, 32);

    op(1'b1, 1'b1, 19'd0, lat);
    chk("neg1_cos", cos_o, 566548, 32);
    chk("neg1_sin", sin_o, -882345, 32);

    // continuous start: accepts at 0, 18, 36
    @(negedge clk);
    sign_i = 1'b0; integer_i = 1'b0; fractional_i = 19'd262144; start = 1'b1;
    nd = 0; d0 = -1; d1 = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done_o) begin
        if (nd == 0) d0 = k;
        else if (nd == 1) d1 = k;
        nd++;
      end
    end
    start = 1'b0;
    chk("b2b_count", nd, 2, 0);
    chk("b2b_first", d0, 17, 0);
    chk("b2b_second", d1, 35, 0);
    n = 0;
    while (!done_o && n < 40) begin @(posedge clk); #1; n++; end
    chk("b2b_drain", n, 14, 0);
    chk("half_cos", cos_o, 920192, 32);
    chk("half_sin", sin_o, 502704, 32);

    op(1'b0, 1'b1, 19'd524287, lat);
    chk("oor_rerr", range_err_o, 1, 0);
    op(1'b0, 1'b0, 19'd262144, lat);
    chk("oor_clear", range_err_o, 0, 0);
    op(1'b0, 1'b1, 19'd524287, lat);
    chk("oor_rerr2", range_err_o, 1, 0);

    // reset mid-run discards the operation
    @(negedge clk);
    sign_i = 1'b0; integer_i = 1'b0; fractional_i = 19'd262144; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    nd = 0;
    repeat (25) begin @(posedge clk); #1; if (done_o) nd++; end
    chk("rstrun_no_done", nd, 0, 0);
    chk("rstrun_cos", cos_o, 0, 0);
    chk("rstrun_sin", sin_o, 0, 0);
    chk("rstrun_rerr", range_err_o, 0, 0);
    chk("rstrun_busy", busy_o, 0, 0);
    op(1'b0, 1'b0, 19'd262144, lat);
    chk("after_rst_lat", lat, 17, 0);
    chk("after_rst_cos", cos_o, 920192, 32);
    chk("after_rst_sin", sin_o, 502704, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
